// File: rtl/systolic_mm_tile_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply tile.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  // Zero steps needed to push the last injected operand through the far corner PE.
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int k_width(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int row_idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_mm_tile_if.sv
// Operand and result streams of the systolic tile; the tile sits on the slave side.
interface systolic_mm_tile_if
  import systolic_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) ();
  localparam int RW = row_idx_width(N);

  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] a_vec;
  logic [N*DATA_W-1:0] b_vec;
  logic                out_valid;
  logic                out_ready;
  logic [N*ACC_W-1:0]  out_row;
  logic [RW-1:0]       out_row_idx;
  logic                out_last;

  modport master (
    output in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, out_last
  );

  modport slave (
    input  in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, out_last
  );
endinterface

// File: rtl/systolic_mm_tile_pe.sv
// One output-stationary MAC cell: accumulates a*b and forwards a right, b down.
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk_buf,
  input  logic                     rst,
  input  logic                     step,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    prod  = a_in * b_in;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (step) begin
      a_d   = a_in;
      b_d   = b_in;
      // Sign-extended product, wrapping modulo 2^ACC_W.
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;
endmodule

// File: rtl/systolic_mm_tile.sv
// N x N output-stationary systolic tile: skews operand lanes, steps the PE grid on
// accepted beats, drains 2N-1 zero steps, then streams C out one row per handshake.
module systolic_mm_tile
  import systolic_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 24,
  parameter  int K_MAX  = 256,
  localparam int KW     = k_width(K_MAX),
  localparam int RW     = row_idx_width(N)
) (
  input  logic              clk_buf,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              accumulate,
  output logic              busy,
  output logic              done,
  systolic_mm_tile_if.slave io
);
  localparam int DRAIN_CYC = drain_len(N);
  localparam int DCW       = $clog2(DRAIN_CYC + 1);

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d, beat_q, beat_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic [RW-1:0]      row_q, row_d, row_pick;
  logic               busy_q, busy_d, in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic               done_q, done_d;
  logic [N*ACC_W-1:0] out_row_q, out_row_d, row_vec;
  logic               beat, out_hs, step, clr;

  logic signed [DATA_W-1:0] a_inj [N];
  logic signed [DATA_W-1:0] b_inj [N];
  logic signed [DATA_W-1:0] a_edge [N];
  logic signed [DATA_W-1:0] b_edge [N];
  logic signed [DATA_W-1:0] a_h [N][N+1];
  logic signed [DATA_W-1:0] b_v [N+1][N];
  logic signed [ACC_W-1:0]  acc [N][N];

  assign beat   = io.in_valid & in_ready_q;
  assign out_hs = out_valid_q & io.out_ready;
  assign step   = beat | (state_q == DRAIN);
  assign clr    = (state_q == IDLE) & start & ~accumulate;

  // Outside LOAD the lanes carry zeros, which is what flushes the array in DRAIN.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
      if (state_q == LOAD) begin
        a_inj[i] = io.a_vec[i*DATA_W +: DATA_W];
        b_inj[i] = io.b_vec[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_inj[gi];
      assign b_edge[gi] = b_inj[gi];
    end else begin : g_sr
      logic signed [DATA_W-1:0] a_sr_q [gi];
      logic signed [DATA_W-1:0] a_sr_d [gi];
      logic signed [DATA_W-1:0] b_sr_q [gi];
      logic signed [DATA_W-1:0] b_sr_d [gi];

      always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        if (clr) begin
          for (int k = 0; k < gi; k++) begin
            a_sr_d[k] = '0;
            b_sr_d[k] = '0;
          end
        end else if (step) begin
          a_sr_d[0] = a_inj[gi];
          b_sr_d[0] = b_inj[gi];
          for (int k = 1; k < gi; k++) begin
            a_sr_d[k] = a_sr_q[k-1];
            b_sr_d[k] = b_sr_q[k-1];
          end
        end
      end

      always_ff @(posedge clk_buf or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) begin
            a_sr_q[k] <= '0;
            b_sr_q[k] <= '0;
          end
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end

      assign a_edge[gi] = a_sr_q[gi-1];
      assign b_edge[gi] = b_sr_q[gi-1];
    end

    assign a_h[gi][0] = a_edge[gi];
    assign b_v[0][gi] = b_edge[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk_buf (clk_buf),
        .rst     (rst),
        .step    (step),
        .clr     (clr),
        .a_in    (a_h[gi][gj]),
        .b_in    (b_v[gi][gj]),
        .a_out   (a_h[gi][gj+1]),
        .b_out   (b_v[gi+1][gj]),
        .acc     (acc[gi][gj])
      );
    end
  end

  // Row 0 is loaded on OUT entry, the following row on each handshake.
  assign row_pick = (state_q == OUT) ? row_q + 1'b1 : '0;

  always_comb begin
    for (int j = 0; j < N; j++) row_vec[j*ACC_W +: ACC_W] = acc[row_pick][j];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    row_d       = row_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_row_d   = out_row_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        k_d     = k_len;
        beat_d  = '0;
        drain_d = '0;
        row_d   = '0;
        busy_d  = 1'b1;
        if (k_len != '0) begin
          state_d    = LOAD;
          in_ready_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      LOAD: if (beat) begin
        beat_d = beat_q + 1'b1;
        if (beat_q == k_q - 1'b1) begin
          state_d    = DRAIN;
          in_ready_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DCW'(DRAIN_CYC - 1)) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          row_d       = '0;
          out_row_d   = row_vec;
        end
      end
      OUT: if (out_hs) begin
        if (row_q == RW'(N - 1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          row_d      = row_q + 1'b1;
          out_row_d  = row_vec;
          out_last_d = (row_q == RW'(N - 2));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_row_q   <= out_row_d;
      done_q      <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_row     = out_row_q;
  assign io.out_row_idx = row_q;
  assign io.out_last    = out_last_q;
endmodule

// File: tb/tb_systolic_mm_tile.sv
// Bench for systolic_mm_tile: directed and randomized runs compared against a plain
// matrix-product model, including stalls on both streams and mid-run resets.
module tb_systolic_mm_tile;
  import systolic_pkg::*;

  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int K_MAX  = 256;
  localparam int KW     = k_width(K_MAX);
  localparam int VW     = N * ACC_W;

  logic          clk_buf = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          accumulate = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done;

  systolic_mm_tile_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) io ();

  systolic_mm_tile #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
    .clk_buf    (clk_buf),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .accumulate (accumulate),
    .busy       (busy),
    .done       (done),
    .io         (io)
  );

  always #5 clk_buf = ~clk_buf;

  int n_checks = 0;
  int n_fail   = 0;

  // a_mat[k][i] = A[i][k], b_mat[k][j] = B[k][j]
  logic signed [DATA_W-1:0] a_mat [K_MAX][N];
  logic signed [DATA_W-1:0] b_mat [K_MAX][N];
  logic signed [ACC_W-1:0]  c_model [N][N];

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DATA_W-1:0] pack_a(input int kk);
    logic [N*DATA_W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = a_mat[kk][i];
    return v;
  endfunction

  function automatic logic [N*DATA_W-1:0] pack_b(input int kk);
    logic [N*DATA_W-1:0] v;
    for (int j = 0; j < N; j++) v[j*DATA_W +: DATA_W] = b_mat[kk][j];
    return v;
  endfunction

  task automatic check_reset_outputs(input string when);
    check({when, "_busy"}, busy, 1'b0);
    check({when, "_in_ready"}, io.in_ready, 1'b0);
    check({when, "_out_valid"}, io.out_valid, 1'b0);
    check({when, "_out_last"}, io.out_last, 1'b0);
    check({when, "_done"}, done, 1'b0);
    check({when, "_out_row"}, io.out_row, '0);
    check({when, "_out_row_idx"}, io.out_row_idx, '0);
  endtask

  // Raise reset between edges; the model loses C because the accumulators are cleared.
  task automatic do_abort(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(posedge clk_buf); #1;
    rst = 1'b0;
    start = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_model[i][j] = '0;
  endtask

  // Called #1 after a clock edge with the DUT idle.
  task automatic run(input int k, input bit accum, input int gap_max, input bit rdy_rand,
                     input int abort_mode, input bit chk_len);
    logic signed [ACC_W-1:0] exp_c [N][N];
    logic [VW-1:0] exp_row;
    int beats, gap, cyc, lat, r, guard;
    bit rdy, hs;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_c[i][j] = accum ? c_model[i][j] : '0;
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          exp_c[i][j] = exp_c[i][j] + ACC_W'(int'(a_mat[kk][i]) * int'(b_mat[kk][j]));

    start = 1'b1;
    k_len = KW'(k);
    accumulate = accum;
    @(posedge clk_buf); #1;
    start = 1'b0;
    accumulate = ~accum;
    k_len = KW'($urandom_range(K_MAX, 0));
    cyc = 0;
    check("busy_after_start", busy, 1'b1);
    check("in_ready_after_start", io.in_ready, k > 0);

    beats = 0;
    guard = 0;
    gap = $urandom_range(gap_max, 0);
    while (beats < k && guard < k * 8 + 64) begin
      check("in_ready_held_in_load", io.in_ready, 1'b1);
      if (gap > 0) begin
        io.in_valid = 1'b0;
        gap--;
      end else begin
        io.in_valid = 1'b1;
        io.a_vec = pack_a(beats);
        io.b_vec = pack_b(beats);
      end
      rdy = io.in_ready;
      @(posedge clk_buf); #1;
      cyc++;
      guard++;
      if (io.in_valid && rdy) begin
        beats++;
        gap = $urandom_range(gap_max, 0);
      end
      if (abort_mode == 1 && beats == k / 2) begin
        do_abort("abort_load");
        return;
      end
    end
    if (beats < k) check("load_timeout", 1'b0, 1'b1);

    // Junk operands and a stray start must be ignored from here on.
    io.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      io.a_vec[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      io.b_vec[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    check("in_ready_after_last", io.in_ready, 1'b0);
    start = 1'b1;
    lat = 0;
    while (!io.out_valid && lat < 4 * N) begin
      @(posedge clk_buf); #1;
      start = 1'b0;
      lat++;
      cyc++;
    end
    start = 1'b0;
    check("drain_latency", lat, 2 * N - 1);

    r = 0;
    guard = 0;
    while (r < N && guard < N * 32) begin
      for (int j = 0; j < N; j++) exp_row[j*ACC_W +: ACC_W] = exp_c[r][j];
      check("out_valid", io.out_valid, 1'b1);
      check("out_row_idx", io.out_row_idx, r);
      check("out_row", io.out_row, exp_row);
      check("out_last", io.out_last, r == N - 1);
      check("done_low_in_out", done, 1'b0);
      if (abort_mode == 2 && r == N / 2) begin
        do_abort("abort_out");
        return;
      end
      io.out_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      hs = io.out_ready & io.out_valid;
      @(posedge clk_buf); #1;
      cyc++;
      guard++;
      if (hs) r++;
    end
    io.out_ready = 1'b0;
    io.in_valid = 1'b0;
    if (r < N) check("out_timeout", 1'b0, 1'b1);
    check("done_pulse", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("out_valid_at_done", io.out_valid, 1'b0);
    if (chk_len) check("run_cycles", cyc + 1, 1 + k + (2 * N - 1) + N);
    @(posedge clk_buf); #1;
    check("done_one_cycle", done, 1'b0);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_model[i][j] = exp_c[i][j];
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        a_mat[kk][i] = DATA_W'($urandom);
        b_mat[kk][i] = DATA_W'($urandom);
      end
  endtask

  task automatic fill_zero();
    for (int kk = 0; kk < K_MAX; kk++)
      for (int i = 0; i < N; i++) begin
        a_mat[kk][i] = '0;
        b_mat[kk][i] = '0;
      end
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    io.a_vec = '0;
    io.b_vec = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_model[i][j] = '0;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk_buf);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk_buf); #1;

    // 2x2 product in the top-left corner, no stalls
    fill_zero();
    a_mat[0][0] = 8'sd1; a_mat[0][1] = 8'sd3;
    a_mat[1][0] = 8'sd2; a_mat[1][1] = 8'sd4;
    b_mat[0][0] = 8'sd5; b_mat[0][1] = 8'sd6;
    b_mat[1][0] = 8'sd7; b_mat[1][1] = 8'sd8;
    run(2, 1'b0, 0, 1'b0, 0, 1'b1);
    run(2, 1'b1, 0, 1'b0, 0, 1'b1);
    run(0, 1'b0, 0, 1'b0, 0, 1'b1);

    // Identity times B with input gaps
    fill_zero();
    for (int kk = 0; kk < N; kk++)
      for (int i = 0; i < N; i++) begin
        a_mat[kk][i] = (i == kk) ? 8'sd1 : 8'sd0;
        b_mat[kk][i] = DATA_W'(N * kk + i);
      end
    run(N, 1'b0, 5, 1'b0, 0, 1'b0);

    // Full-depth extremes
    for (int kk = 0; kk < K_MAX; kk++)
      for (int i = 0; i < N; i++) begin
        a_mat[kk][i] = -8'sd128;
        b_mat[kk][i] = -8'sd128;
      end
    run(K_MAX, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int kk = 0; kk < K_MAX; kk++)
      for (int i = 0; i < N; i++) a_mat[kk][i] = 8'sd127;
    run(K_MAX, 1'b0, 0, 1'b1, 0, 1'b0);

    // Random operands, random stalls on both streams, random accumulate
    for (int t = 0; t < 3; t++) begin
      int kr;
      kr = $urandom_range(20, 1);
      fill_random(kr);
      run(kr, 1'($urandom_range(1, 0)), 3, 1'b1, 0, 1'b0);
    end

    // Reset mid-LOAD and mid-OUT, each followed by a clean accumulating run
    fill_random(12);
    run(12, 1'b1, 1, 1'b0, 1, 1'b0);
    run(12, 1'b1, 2, 1'b1, 0, 1'b0);
    fill_random(12);
    run(12, 1'b0, 0, 1'b0, 2, 1'b0);
    run(12, 1'b1, 0, 1'b1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_mm_tile.md
# systolic_mm_tile

Parametrised N×N output-stationary systolic matrix-multiply tile with its own sequencing. It computes C = A·B (+C when accumulating) for one N×N output tile over a runtime depth K. The block owns input skewing, drain timing, row-serial result readout and valid/ready handshakes on both streams. It sits between the LSTM datapath's operand buffers and the activation stage, replacing fixed-size hand-tiled arrays.

## Interface
- N, default 8: array dimension, rows and columns; N ≥ 2.
- DATA_W, default 8: signed operand width.
- ACC_W, default 24: signed accumulator width.
- K_MAX, default 256: maximum reduction depth per run.
- KW, default $clog2(K_MAX+1): derived localparam for k_len width.
- clk_buf  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- start  in  1: begin a run; sampled in IDLE only.
- k_len  in  KW: reduction depth K, 0..K_MAX; sampled with start.
- accumulate  in  1: 1 keeps previous C; 0 clears C. Sampled with start.
- busy  out  1: high in any state other than IDLE.
- in_valid  in  1: operand beat valid.
- in_ready  out  1: high only in LOAD.
- a_vec  in  N*DATA_W: lane i = A[i][k].
- b_vec  in  N*DATA_W: lane j = B[k][j].
- out_valid  out  1: result row valid.
- out_ready  in  1: result row accepted.
- out_row  out  N*ACC_W: lane j = C[r][j].
- out_row_idx  out  $clog2(N): row index r.
- out_last  out  1: high with row N-1.
- done  out  1: one-cycle pulse after the last row handshake.

## Operation
- FSM states: IDLE, LOAD, DRAIN, OUT.
- IDLE: on start, latch K and accumulate, and clear all PE accumulators if accumulate=0. Go to LOAD if K>0, else go to DRAIN.
- LOAD:
  - A beat is accepted on in_valid & in_ready.
  - Each accepted beat advances the whole array by one step: skew registers, PE operand registers and MACs.
  - With no beat, the array holds. Stalls therefore never misalign data.
  - After the K-th accepted beat, go to DRAIN.
- Skew: row lane i is delayed by i array steps and column lane j by j steps. Skew registers reset and clear to 0.
- PE(i,j):
  - acc += a·b as a signed full product, sign-extended to ACC_W and wrapping modulo 2^ACC_W (no saturation).
  - a is forwarded right and b is forwarded down, each through one register.
- DRAIN: the array advances every cycle with zero injected on all lanes, for exactly 2N-1 cycles, then goes to OUT.
- OUT:
  - Row r = 0..N-1 is presented from the accumulators; out_row_idx = r.
  - Advance on out_valid & out_ready. out_row is held stable while out_ready is low.
  - After row N-1 is accepted: pulse done and go to IDLE.
- Accumulators keep C after OUT, so the next run with accumulate=1 sums onto it. This allows K > K_MAX to be split across runs.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.

## Timing
- Reset values: busy, in_ready, out_valid, out_last and done are 0. out_row and out_row_idx are 0. All accumulators, skew and operand registers are 0. State is IDLE.
- Asserting rst mid-run aborts the run immediately. Partial C is discarded; no done pulse.
- start accepted at edge t: busy=1 and in_ready=1 from t+1.
- Last beat accepted at edge t: in_ready=0 from t+1. out_valid first rises at t+1+(2N-1).
- k_len=0: DRAIN starts at t+1, and C is unchanged (or zero if accumulate=0).
- Minimum run length with no stalls: 1 + K + (2N-1) + N cycles, from start to done.
- done is high in the cycle after the last row handshake, coincident with busy=0.
- out_row is registered. It updates in the cycle after a handshake, or on OUT entry.

## Structure
- Package systolic_pkg holds:
  - the state enum type (IDLE/LOAD/DRAIN/OUT);
  - the drain-length function (2N-1);
  - the KW and row-index width helper functions.
- Sub-module systolic_pe: one MAC with a/b forward registers, step-enable and synchronous clear. It is instantiated N×N in a generate loop.
- Skew lines, FSM, counters (beat, drain, row) and the output mux live in the top module.

## Test plan
- N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], no stalls: rows [19,22] then [43,50]. out_last is on row 1, done fires once, and the cycle count is 1+2+3+2.
- Same operands with accumulate=1 in the second run: rows [38,44] and [86,100]. Then a run with accumulate=0 and k_len=0 gives rows of all zeros.
- N=8, K=8, A = identity, B[k][j] = 8k+j, random in_valid gaps of 0–5 cycles: C = B exactly, and in_ready never drops mid-LOAD.
- N=8, K=256, all operands -128: every C entry = 4194304. Then operands +127/-128 with K=256: -4161536.
- out_ready toggled pseudo-randomly: each row is presented once, in order 0..7, and stays stable while stalled.
- rst asserted in the middle of LOAD, then in the middle of OUT: all outputs return to reset values within the same cycle. A subsequent clean run gives correct C with no leftover partial sums.
